// File: rtl/fios_row_sequencer.sv
// fios_row_sequencer: issue-side controller for one FIOS row R = A*b + C on a
// 17-bit-limb DSP multiply-accumulate slice. Reads A/C limbs, drives the slice
// with per-register-level skew, and collects one result limb per cycle.
// Optional feature macro: FIOS_ROW_CARRY_OUT_EN (issue a flush slot so the final
// carry is emitted as an extra result limb).
module fios_row_sequencer #(
    parameter int unsigned ABREG = 1,
    parameter int unsigned MREG  = 1,
    parameter int unsigned LIMBS = 8
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic [16:0]                b_i,
    output logic                       ready_o,
    output logic                       rd_en_o,
    output logic [$clog2(LIMBS)-1:0]   rd_addr_o,
    input  logic [16:0]                a_data_i,
    input  logic [16:0]                c_data_i,
    output logic [16:0]                dsp_A_o,
    output logic [16:0]                dsp_B_o,
    output logic [33:0]                dsp_C_o,
    output logic                       dsp_CREG_en_o,
    output logic [8:0]                 dsp_OPMODE_o,
    input  logic [33:0]                dsp_P_i,
    output logic                       res_valid_o,
    output logic [16:0]                res_limb_o,
    output logic [$clog2(LIMBS+1)-1:0] res_idx_o,
    output logic                       done_o
);

    localparam int unsigned AW            = $clog2(LIMBS);
    localparam int unsigned IW            = $clog2(LIMBS + 1);
    localparam int unsigned DSP_REG_LEVEL = 1 + ABREG + MREG;
    // OPMODE/C must meet the multiplier output, which lags A/B by ABREG+MREG.
    localparam int unsigned SKEW          = ABREG + MREG - 1;
`ifdef FIOS_ROW_CARRY_OUT_EN
    localparam int unsigned NUM_RES       = LIMBS + 1;
`else
    localparam int unsigned NUM_RES       = LIMBS;
`endif

    localparam logic [8:0] OP_FIRST = 9'b11_000_0101;  // M + C
    localparam logic [8:0] OP_MID   = 9'b11_110_0101;  // M + C + P>>17
    localparam logic [8:0] OP_FLUSH = 9'b00_110_0000;  // P>>17

    typedef enum logic [1:0] {StIdle, StRead, StFlush, StDrain} state_e;

    state_e                   state_q, state_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic [16:0]              b_q, b_d;
    logic                     issue_q, issue_d;
    logic                     first_q, first_d;
    logic                     flush_q, flush_d;
    logic [DSP_REG_LEVEL-1:0] vld_q, vld_d;
    logic [IW-1:0]            res_idx_q, res_idx_d;

    logic [8:0]               slot_op;
    logic [33:0]              slot_c;
    logic                     slot_creg;

    // Upper P bits are the slice's own carry path; only the low limb is collected.
    logic unused_p_hi;
    assign unused_p_hi = ^dsp_P_i[33:17];

    // Row FSM: next state, read strobe, B latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        b_d       = b_q;
        ready_o   = 1'b0;
        rd_en_o   = 1'b0;
        rd_addr_o = '0;
        case (state_q)
            StIdle: begin
                ready_o = 1'b1;
                if (start_i) begin
                    b_d     = b_i;
                    addr_d  = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                rd_en_o   = 1'b1;
                rd_addr_o = addr_q;
                if (addr_q == AW'(LIMBS - 1)) begin
                    addr_d  = '0;
`ifdef FIOS_ROW_CARRY_OUT_EN
                    state_d = StFlush;
`else
                    state_d = StDrain;
`endif
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StFlush: state_d = StDrain;
            StDrain: if (done_o) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Slot markers: an issue slot follows each read by one cycle (read latency).
    always_comb begin
        issue_d = (state_q == StRead);
        first_d = (state_q == StRead) && (addr_q == '0);
`ifdef FIOS_ROW_CARRY_OUT_EN
        flush_d = (state_q == StFlush);
`else
        flush_d = 1'b0;
`endif
    end

    // Per-slot A, OPMODE, C and CREG enable before skew.
    always_comb begin
        dsp_A_o   = '0;
        slot_op   = '0;
        slot_c    = '0;
        slot_creg = 1'b0;
        if (issue_q) begin
            dsp_A_o   = a_data_i;
            slot_c    = {17'b0, c_data_i};
            slot_creg = 1'b1;
            slot_op   = first_q ? OP_FIRST : OP_MID;
        end else if (flush_q) begin
            slot_op = OP_FLUSH;
        end
    end

    assign dsp_B_o = b_q;

    generate
        if (SKEW == 0) begin : g_no_skew
            assign dsp_OPMODE_o  = slot_op;
            assign dsp_C_o       = slot_c;
            assign dsp_CREG_en_o = slot_creg;
        end else begin : g_skew
            logic [SKEW-1:0][8:0]  op_q, op_d;
            logic [SKEW-1:0][33:0] c_q, c_d;
            logic [SKEW-1:0]       creg_q, creg_d;

            // Shift OPMODE/C/CREG_en down the skew line.
            always_comb begin
                op_d      = op_q;
                c_d       = c_q;
                creg_d    = creg_q;
                op_d[0]   = slot_op;
                c_d[0]    = slot_c;
                creg_d[0] = slot_creg;
                for (int i = 1; i < int'(SKEW); i++) begin
                    op_d[i]   = op_q[i-1];
                    c_d[i]    = c_q[i-1];
                    creg_d[i] = creg_q[i-1];
                end
            end

            // Skew line registers, cleared on reset so an aborted row leaves nothing behind.
            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    op_q   <= '0;
                    c_q    <= '0;
                    creg_q <= '0;
                end else begin
                    op_q   <= op_d;
                    c_q    <= c_d;
                    creg_q <= creg_d;
                end
            end

            assign dsp_OPMODE_o  = op_q[SKEW-1];
            assign dsp_C_o       = c_q[SKEW-1];
            assign dsp_CREG_en_o = creg_q[SKEW-1];
        end
    endgenerate

    // Result-valid line tracks each issued slot through the slice pipeline.
    always_comb begin
        vld_d = {vld_q[DSP_REG_LEVEL-2:0], issue_q | flush_q};
    end

    assign res_valid_o = vld_q[DSP_REG_LEVEL-1];
    assign res_limb_o  = res_valid_o ? dsp_P_i[16:0] : '0;
    assign res_idx_o   = res_valid_o ? res_idx_q : '0;
    assign done_o      = res_valid_o && (res_idx_q == IW'(NUM_RES - 1));

    // Result index restarts on each accepted start.
    always_comb begin
        res_idx_d = res_idx_q;
        if (state_q == StIdle && start_i) begin
            res_idx_d = '0;
        end else if (res_valid_o) begin
            res_idx_d = res_idx_q + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            b_q       <= '0;
            issue_q   <= 1'b0;
            first_q   <= 1'b0;
            flush_q   <= 1'b0;
            vld_q     <= '0;
            res_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            b_q       <= b_d;
            issue_q   <= issue_d;
            first_q   <= first_d;
            flush_q   <= flush_d;
            vld_q     <= vld_d;
            res_idx_q <= res_idx_d;
        end
    end

endmodule

// File: tb/tb_fios_row_sequencer.sv
// Bench for fios_row_sequencer: two instances (ABREG=1/MREG=1 and ABREG=0/MREG=1,
// LIMBS=4), each with an operand memory and a behavioural DSP slice.
module tb_fios_row_sequencer;

    localparam int L = 4;
`ifdef FIOS_ROW_CARRY_OUT_EN
    localparam int  NRES  = L + 1;
    localparam bit  CARRY = 1'b1;
`else
    localparam int  NRES  = L;
    localparam bit  CARRY = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start   [2];
    logic [16:0] b_in;
    logic        ready   [2];
    logic        rd_en   [2];
    logic [1:0]  rd_addr [2];
    logic [16:0] a_data  [2];
    logic [16:0] c_data  [2];
    logic [16:0] d_a     [2];
    logic [16:0] d_b     [2];
    logic [33:0] d_c     [2];
    logic        d_creg  [2];
    logic [8:0]  d_op    [2];
    logic [33:0] d_p     [2];
    logic        rv      [2];
    logic [16:0] rl      [2];
    logic [2:0]  ri      [2];
    logic        done    [2];

    logic [16:0] a_mem [2][L];
    logic [16:0] c_mem [2][L];
    logic [16:0] exp_limb [5];

    int n_chk;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned AB = (g == 0) ? 1 : 0;

        fios_row_sequencer #(.ABREG(AB), .MREG(1), .LIMBS(L)) u_dut (
            .clock_i      (clk),
            .reset_i      (rst),
            .start_i      (start[g]),
            .b_i          (b_in),
            .ready_o      (ready[g]),
            .rd_en_o      (rd_en[g]),
            .rd_addr_o    (rd_addr[g]),
            .a_data_i     (a_data[g]),
            .c_data_i     (c_data[g]),
            .dsp_A_o      (d_a[g]),
            .dsp_B_o      (d_b[g]),
            .dsp_C_o      (d_c[g]),
            .dsp_CREG_en_o(d_creg[g]),
            .dsp_OPMODE_o (d_op[g]),
            .dsp_P_i      (d_p[g]),
            .res_valid_o  (rv[g]),
            .res_limb_o   (rl[g]),
            .res_idx_o    (ri[g]),
            .done_o       (done[g])
        );

        // Operand memory, read latency 1.
        always @(posedge clk) begin
            if (rd_en[g]) begin
                a_data[g] <= a_mem[g][rd_addr[g]];
                c_data[g] <= c_mem[g][rd_addr[g]];
            end
        end

        // Behavioural slice: AB input regs, one M reg, CREG, OPMODE reg, P reg.
        logic [16:0] a_r, b_r, a_e, b_e;
        logic [33:0] m_r, m_c, c_r, p_r, sum;
        logic [8:0]  op_r;
        always_comb begin
            a_e = (AB != 0) ? a_r : d_a[g];
            b_e = (AB != 0) ? b_r : d_b[g];
            m_c = {17'b0, a_e} * {17'b0, b_e};
            sum = '0;
            if (op_r[3:0] == 4'b0101) sum = sum + m_r;
            if (op_r[8:7] == 2'b11)   sum = sum + c_r;
            if (op_r[6:4] == 3'b110)  sum = sum + {17'b0, p_r[33:17]};
        end
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                a_r <= '0; b_r <= '0; m_r <= '0; c_r <= '0; op_r <= '0; p_r <= '0;
            end else begin
                a_r  <= d_a[g];
                b_r  <= d_b[g];
                m_r  <= m_c;
                op_r <= d_op[g];
                if (d_creg[g]) c_r <= d_c[g];
                p_r  <= sum;
            end
        end
        assign d_p[g] = p_r;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int skew_of(input int g);
        return (g == 0) ? 1 : 0;
    endfunction

    task automatic check_idle(input int g, input string ctx);
        chk($sformatf("%s ready g%0d", ctx, g), ready[g], 1);
        chk($sformatf("%s rd_en g%0d", ctx, g), rd_en[g], 0);
        chk($sformatf("%s op g%0d", ctx, g), d_op[g], 0);
        chk($sformatf("%s A g%0d", ctx, g), d_a[g], 0);
        chk($sformatf("%s B g%0d", ctx, g), d_b[g], 0);
        chk($sformatf("%s C g%0d", ctx, g), d_c[g], 0);
        chk($sformatf("%s creg g%0d", ctx, g), d_creg[g], 0);
        chk($sformatf("%s rv g%0d", ctx, g), rv[g], 0);
        chk($sformatf("%s limb g%0d", ctx, g), rl[g], 0);
        chk($sformatf("%s idx g%0d", ctx, g), ri[g], 0);
        chk($sformatf("%s done g%0d", ctx, g), done[g], 0);
    endtask

    // Per-cycle check of slice drive at row cycle n.
    task automatic check_cycle(input int g, input int n, input logic [16:0] bval);
        int s;
        int t;
        logic [8:0]  eop;
        logic [33:0] ec;
        logic [16:0] ea;
        s   = n - 2 - skew_of(g);
        t   = n - 2;
        eop = 9'h000;
        if (s == 0) eop = 9'h185;
        else if (s > 0 && s < L) eop = 9'h1E5;
        else if (s == L && CARRY) eop = 9'h060;
        ec = (s >= 0 && s < L) ? {17'b0, c_mem[g][s]} : 34'h0;
        ea = (t >= 0 && t < L) ? a_mem[g][t] : 17'h0;
        chk($sformatf("op g%0d n%0d", g, n), d_op[g], eop);
        chk($sformatf("creg g%0d n%0d", g, n), d_creg[g], (s >= 0 && s < L));
        chk($sformatf("C g%0d n%0d", g, n), d_c[g], ec);
        chk($sformatf("A g%0d n%0d", g, n), d_a[g], ea);
        chk($sformatf("B g%0d n%0d", g, n), d_b[g], bval);
        chk($sformatf("rd_en g%0d n%0d", g, n), rd_en[g], (n >= 1 && n <= L));
        if (n >= 1 && n <= L) chk($sformatf("rd_addr g%0d n%0d", g, n), rd_addr[g], n - 1);
        chk($sformatf("ready g%0d n%0d", g, n), ready[g], 0);
    endtask

    // Starts a row on instance g (caller must be in a ready cycle) and checks it.
    task automatic run_row(input int g, input logic [16:0] bval, input int first,
                           input bit hold);
        int k;
        bit seen;
        b_in     = bval;
        start[g] = 1'b1;
        step();
        b_in = 17'h0AAAA;
        if (!hold) start[g] = 1'b0;
        k    = 0;
        seen = 1'b0;
        for (int n = 1; n <= 24 && !seen; n++) begin
            if (n > 1) step();
            check_cycle(g, n, bval);
            if (rv[g]) begin
                chk($sformatf("idx g%0d n%0d", g, n), ri[g], k);
                if (k < 5) chk($sformatf("limb g%0d k%0d", g, k), rl[g], exp_limb[k]);
                chk($sformatf("res_cycle g%0d k%0d", g, k), n, first + k);
                chk($sformatf("done g%0d k%0d", g, k), done[g], (k == NRES - 1));
                if (done[g]) seen = 1'b1;
                k++;
            end else begin
                chk($sformatf("done_quiet g%0d n%0d", g, n), done[g], 0);
            end
        end
        chk($sformatf("n_results g%0d", g), k, NRES);
        chk($sformatf("done_seen g%0d", g), seen, 1);
        step();
        chk($sformatf("ready_after g%0d", g), ready[g], 1);
    endtask

    task automatic load_case1(input int g);
        for (int i = 0; i < L; i++) begin
            a_mem[g][i] = 17'(i + 1);
            c_mem[g][i] = 17'h0;
        end
        exp_limb[0] = 17'h1; exp_limb[1] = 17'h2; exp_limb[2] = 17'h3;
        exp_limb[3] = 17'h4; exp_limb[4] = 17'h0;
    endtask

    task automatic load_case2(input int g);
        for (int i = 0; i < L; i++) begin
            a_mem[g][i] = 17'h1FFFF;
            c_mem[g][i] = 17'h1FFFF;
        end
        exp_limb[0] = 17'h00000; exp_limb[1] = 17'h1FFFF; exp_limb[2] = 17'h1FFFF;
        exp_limb[3] = 17'h1FFFF; exp_limb[4] = 17'h1FFFF;
    endtask

    initial begin
        bit anyv;
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        b_in     = 17'h0;
        #12;
        check_idle(0, "in_reset");
        check_idle(1, "in_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        check_idle(0, "post_reset");

        // Case 1: b=1, A=[1,2,3,4], C=0 on both skew configurations.
        load_case1(0);
        run_row(0, 17'h1, 5, 1'b0);
        load_case1(1);
        run_row(1, 17'h1, 4, 1'b0);

        // Case 2: all-ones operands exercise the full carry chain.
        load_case2(0);
        run_row(0, 17'h1FFFF, 5, 1'b0);
        load_case2(1);
        run_row(1, 17'h1FFFF, 4, 1'b0);

        // start held high: second row only after ready, index restarts.
        load_case1(0);
        run_row(0, 17'h1, 5, 1'b1);
        run_row(0, 17'h1, 5, 1'b0);

        // Reset at cycle 4 of a row aborts it.
        b_in     = 17'h1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle(0, "abort");
        anyv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            anyv = anyv | rv[0] | rv[1];
        end
        chk("no_valid_after_abort", anyv, 0);

        // Recovery row after abort.
        load_case2(0);
        run_row(0, 17'h1FFFF, 5, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fios_row_sequencer.md
# fios_row_sequencer

Issue-side controller for the 17-bit-limb DSP multiply-accumulate slice. Executes one FIOS row R = A·b + C over LIMBS limbs: reads A/C limbs from operand memory, drives the DSP slice's A/B/C/OPMODE/CREG_en inputs with the correct per-register-level skew, and collects one 17-bit result limb per cycle from the slice's P output, chaining carries through the slice's P>>17 feedback.

## Interface
- ABREG, 1, DSP A/B input register stages (0 or 1); must match the driven slice
- MREG, 1, DSP multiplier register stages (0 or 1); ABREG+MREG ≥ 1 required
- LIMBS, 8, limbs per row (≥ 2)
- clock_i  in  1  clock
- reset_i  in  1  async active-high reset
- start_i  in  1  start a row; sampled only when ready_o=1
- b_i  in  17  row multiplier limb, latched on accepted start
- ready_o  out  1  idle, start accepted
- rd_en_o  out  1  operand memory read strobe (read latency 1)
- rd_addr_o  out  $clog2(LIMBS)  limb index
- a_data_i  in  17  A limb, valid cycle after rd_en_o
- c_data_i  in  17  C limb, valid cycle after rd_en_o
- dsp_A_o  out  17  to slice A_i
- dsp_B_o  out  17  to slice B_i
- dsp_C_o  out  34  to slice C_i (zero-extended c limb)
- dsp_CREG_en_o  out  1  to slice CREG_en_i
- dsp_OPMODE_o  out  9  to slice OPMODE_i
- dsp_P_i  in  34  from slice P_o
- res_valid_o  out  1  res_limb_o valid
- res_limb_o  out  17  result limb
- res_idx_o  out  $clog2(LIMBS+1)  result limb index
- done_o  out  1  one-cycle pulse with last result

## Operation
- FSM: IDLE → READ (LIMBS cycles) → FLUSH (1 cycle) → DRAIN → IDLE.
- IDLE: ready_o=1. start_i=1 latches b_i into B register, goes READ. start_i outside IDLE ignored.
- READ: rd_en_o=1, rd_addr_o=0..LIMBS-1 incrementing; last address → FLUSH.
- Issue slot j (cycle after read j): dsp_A_o=a_data_i, dsp_B_o=B register; C limb and OPMODE enter a skew line of ABREG+MREG-1 stages (0 stages = direct).
- OPMODE per slot: j=0 → 9'b11_000_0101 (M+C); 0<j<LIMBS → 9'b11_110_0101 (M+C+P>>17); flush slot → 9'b00_110_0000 (P>>17). dsp_CREG_en_o=1 with every non-flush OPMODE, 0 otherwise. dsp_A_o=0 on flush slot.
- Idle/default outputs: dsp_OPMODE_o=0, dsp_A_o=0, dsp_C_o=0, dsp_CREG_en_o=0.
- A result-valid shift line of depth DSP_REG_LEVEL=1+ABREG+MREG tracks issued slots; when it emerges, res_valid_o=1, res_limb_o=dsp_P_i[16:0], res_idx_o increments from 0.
- Arithmetic: a·b+c+carry ≤ 2^34-1, so P never exceeds 34 bits; final carry ≤ 2^17-1 fits one limb. Total LIMBS+1 results.
- DRAIN: wait until last result emitted; done_o pulses with it; IDLE next cycle.
- reset_i mid-row: abort immediately, all skew/valid lines cleared, no further res_valid_o; B register cleared.

## Timing
- Reset values: ready_o=1, all other outputs 0.
- Cycle 0 = clock edge sampling start_i. rd_en_o high cycles 1..LIMBS; issue slots cycles 2..LIMBS+1; flush slot cycle LIMBS+2.
- First res_valid_o at cycle 2+DSP_REG_LEVEL; results contiguous, one per cycle, last (carry) at cycle 2+DSP_REG_LEVEL+LIMBS with done_o.
- ready_o=1 again cycle after done_o; back-to-back start accepted there (row period LIMBS+DSP_REG_LEVEL+3).
- OPMODE/C for slot j reach the slice exactly ABREG+MREG-1 cycles after that slot's A/B.

## Configuration
- FIOS_ROW_CARRY_OUT_EN defined: flush slot issued, LIMBS+1 results, done_o with carry limb.
- Undefined: no FLUSH state/slot, LIMBS results, done_o with limb LIMBS-1; final carry discarded (left in slice P).

## Test plan
- LIMBS=4, ABREG=MREG=1, b=1, A=[1,2,3,4], C=0 → results 1,2,3,4,0 at cycles 5..9; done_o cycle 9.
- A=C=0x1FFFF all limbs, b=0x1FFFF → results 0x00000,0x1FFFF,0x1FFFF,0x1FFFF, carry 0x1FFFF.
- ABREG=0, MREG=1: OPMODE coincident with A; first result cycle 4; same values as case 1.
- start_i held high throughout row → second row begins only after ready_o; no overlap, res_idx_o restarts at 0.
- reset_i pulsed at cycle 4 of a row → all outputs 0 next cycle, ready_o=1, no res_valid_o afterward.
- Macro undefined, case 2 stimulus → 4 results, done_o with 0x1FFFF at idx 3, no flush OPMODE observed.
